// File: rtl/ysyx_23060184_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter: FSM states, owner codes
// and the default address/data width.
package ysyx_23060184_mem_arbiter_pkg;

    localparam int ARB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060184_mem_arbiter_watchdog.sv
// Grant-duration watchdog: counts cycles while enabled and flags the final
// permitted cycle so the arbiter can abort a hung memory transaction.
module ysyx_23060184_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Count starts at 0 on the first grant cycle, so this fires on cycle TIMEOUT_CYCLES.
    assign expired = enable && (count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ysyx_23060184_mem_arbiter.sv
// IFU/LSU arbiter for the single SoC memory port with a grant watchdog.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate instead of LSU priority.
module ysyx_23060184_mem_arbiter
    import ysyx_23060184_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req,
    input  logic [DATA_WIDTH-1:0] ifu_addr,
    input  logic                  lsu_req,
    input  logic [DATA_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_read,
    input  logic                  lsu_write,
    input  logic                  mem_valid,
    input  logic                  mem_idle,
    output logic                  grant,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ifu_done,
    output logic                  lsu_done,
    output logic                  owner,
    output logic                  timeout_err
);

    arb_state_t state, state_next;
    logic       owner_next;
    logic       winner;
    logic       ifu_done_next, lsu_done_next, timeout_next;
    logic       expired;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner, last_owner_next;

    always_comb begin
        if (ifu_req && lsu_req) begin
            winner = ~last_owner;
        end else begin
            winner = lsu_req ? OWNER_LSU : OWNER_IFU;
        end
    end
`else
    assign winner = lsu_req ? OWNER_LSU : OWNER_IFU;
`endif

    ysyx_23060184_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ARB_GRANT),
        .enable (state == ARB_GRANT),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            owner       <= OWNER_IFU;
            ifu_done    <= 1'b0;
            lsu_done    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner  <= OWNER_IFU;
`endif
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            ifu_done    <= ifu_done_next;
            lsu_done    <= lsu_done_next;
            timeout_err <= timeout_next;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner  <= last_owner_next;
`endif
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        ifu_done_next   = 1'b0;
        lsu_done_next   = 1'b0;
        timeout_next    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_next = last_owner;
`endif
        case (state)
            ARB_IDLE: begin
                if (ifu_req || lsu_req) begin
                    state_next = ARB_GRANT;
                    owner_next = winner;
                end
            end
            ARB_GRANT: begin
                // A completion on the last watchdog cycle wins over the abort.
                if (mem_valid || expired) begin
                    state_next      = ARB_RELEASE;
                    ifu_done_next   = (owner == OWNER_IFU);
                    lsu_done_next   = (owner == OWNER_LSU);
                    timeout_next    = ~mem_valid;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_next = owner;
`endif
                end
            end
            ARB_RELEASE: begin
                if (mem_idle) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign grant = (state == ARB_GRANT);

    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (state == ARB_GRANT) begin
            if (owner == OWNER_LSU) begin
                mem_addr  = lsu_addr;
                mem_read  = lsu_read;
                mem_write = lsu_write;
            end else begin
                mem_addr  = ifu_addr;
                mem_read  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Self-checking bench for ysyx_23060184_mem_arbiter: directed vector table,
// multi-cycle corner sequences and a randomized run against a reference model.
module tb_ysyx_23060184_mem_arbiter;

    localparam int TO = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, lsu_req, lsu_read, lsu_write, mem_valid, mem_idle;
    logic [31:0] ifu_addr, lsu_addr;
    logic        grant, mem_read, mem_write, ifu_done, lsu_done, owner, timeout_err;
    logic [31:0] mem_addr;

    int checks = 0;
    int errors = 0;

    ysyx_23060184_mem_arbiter #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ifu_req    (ifu_req),
        .ifu_addr   (ifu_addr),
        .lsu_req    (lsu_req),
        .lsu_addr   (lsu_addr),
        .lsu_read   (lsu_read),
        .lsu_write  (lsu_write),
        .mem_valid  (mem_valid),
        .mem_idle   (mem_idle),
        .grant      (grant),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ifu_done   (ifu_done),
        .lsu_done   (lsu_done),
        .owner      (owner),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // in  = {ifu_req, lsu_req, lsu_read, lsu_write, mem_valid, mem_idle}
    // exp = {grant, owner, mem_read, mem_write, ifu_done, lsu_done, timeout_err}
    typedef struct {
        logic [5:0]  in;
        logic [31:0] ia;
        logic [31:0] la;
        logic [6:0]  exp;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs[14];

    // Reference model state: who holds the port, for how long, and whether
    // the port is draining after a completion.
    bit m_busy, m_drain, m_who, m_last;
    int m_age;
    bit e_idone, e_ldone, e_to;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] in, input logic [31:0] ia, input logic [31:0] la);
        {ifu_req, lsu_req, lsu_read, lsu_write, mem_valid, mem_idle} = in;
        ifu_addr = ia;
        lsu_addr = la;
    endtask

    task automatic check(input string name, input logic [6:0] e, input logic [31:0] ea);
        logic [6:0] act;
        bit         bad;
        act = {grant, owner, mem_read, mem_write, ifu_done, lsu_done, timeout_err};
        checks++;
        bad = (act[6] !== e[6]) || (e[6] && act[5] !== e[5]) || (act[4:0] !== e[4:0]) ||
              (mem_addr !== ea);
        if (bad) begin
            errors++;
            $display("FAIL %s: got {g,o,r,w,id,ld,to}=%b addr=%h, expected %b addr=%h",
                     name, act, mem_addr, e, ea);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(6'b000000, 32'h0, 32'h0);
        tick();
        tick();
        check("reset", 7'b0000000, 32'h0);
        rst = 1'b0;
        m_busy = 0; m_drain = 0; m_who = 0; m_last = 0; m_age = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        e_idone = 0; e_ldone = 0; e_to = 0;
        if (m_busy) begin
            if (mem_valid || m_age == TO - 1) begin
                e_idone = !m_who;
                e_ldone = m_who;
                e_to    = !mem_valid;
                m_last  = m_who;
                m_busy  = 0;
                m_drain = 1;
            end else begin
                m_age++;
            end
        end else if (m_drain) begin
            if (mem_idle) m_drain = 0;
        end else if (ifu_req || lsu_req) begin
            if (ifu_req && lsu_req) m_who = RR ? !m_last : 1'b1;
            else                    m_who = lsu_req;
            m_busy = 1;
            m_age  = 0;
        end
    endtask

    task automatic model_check();
        logic [6:0]  e;
        logic [31:0] ea;
        e[6] = m_busy;
        e[5] = m_who;
        e[4] = m_busy && (m_who ? lsu_read : 1'b1);
        e[3] = m_busy && m_who && lsu_write;
        e[2] = e_idone;
        e[1] = e_ldone;
        e[0] = e_to;
        ea   = m_busy ? (m_who ? lsu_addr : ifu_addr) : 32'h0;
        check("random", e, ea);
    endtask

    initial begin
        logic [31:0] A, B;
        int          mv_thr;
        bit          got;
        A = 32'h8000_0000;
        B = 32'hA000_0004;

        vecs[0]  = '{6'b100000, A, 32'h0, 7'b1010000, A};
        vecs[1]  = '{6'b100000, A, 32'h0, 7'b1010000, A};
        vecs[2]  = '{6'b100000, A, 32'h0, 7'b1010000, A};
        vecs[3]  = '{6'b100000, A, 32'h0, 7'b1010000, A};
        vecs[4]  = '{6'b100000, A, 32'h0, 7'b1010000, A};
        vecs[5]  = '{6'b100010, A, 32'h0, 7'b0000100, 32'h0};
        vecs[6]  = '{6'b000000, A, 32'h0, 7'b0000000, 32'h0};
        vecs[7]  = '{6'b000001, A, 32'h0, 7'b0000000, 32'h0};
        vecs[8]  = '{6'b110100, A, B,     7'b1101000, B};
        vecs[9]  = '{6'b110110, A, B,     7'b0000010, 32'h0};
        vecs[10] = '{6'b100001, A, B,     7'b0000000, 32'h0};
        vecs[11] = '{6'b100000, A, B,     7'b1010000, A};
        vecs[12] = '{6'b100010, A, B,     7'b0000100, 32'h0};
        vecs[13] = '{6'b000001, A, B,     7'b0000000, 32'h0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].in, vecs[i].ia, vecs[i].la);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ea);
        end

        // Watchdog abort: 16 grant cycles, abort pulse on the 17th.
        set_in(6'b011000, 32'h0, 32'h1000_0010);
        for (int i = 1; i <= TO; i++) begin
            tick();
            check("to_grant", 7'b1110000, 32'h1000_0010);
        end
        tick();
        check("to_fire", 7'b0000011, 32'h0);
        lsu_req = 1'b0;
        tick();
        check("to_release", 7'b0000000, 32'h0);
        tick();
        check("to_hold", 7'b0000000, 32'h0);
        mem_idle = 1'b1;
        tick();
        check("to_idle", 7'b0000000, 32'h0);

        // Completion on the final watchdog cycle must not flag a timeout.
        set_in(6'b011000, 32'h0, 32'h1000_0020);
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (i == 1 || i == TO) check("last_grant", 7'b1110000, 32'h1000_0020);
        end
        mem_valid = 1'b1;
        tick();
        check("last_done", 7'b0000010, 32'h0);
        set_in(6'b000001, 32'h0, 32'h0);
        tick();

        // Asynchronous reset in the middle of a grant.
        set_in(6'b011000, 32'h0, 32'h2000_0000);
        tick();
        check("rst_pre", 7'b1110000, 32'h2000_0000);
        tick();
        #3 rst = 1'b1;
        #1 check("rst_async", 7'b0000000, 32'h0);
        tick();
        check("rst_nodone", 7'b0000000, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_regrant", 7'b1110000, 32'h2000_0000);
        mem_valid = 1'b1;
        tick();
        check("rst_done", 7'b0000010, 32'h0);
        set_in(6'b000001, 32'h0, 32'h0);
        tick();

        // Both requesters held continuously: 4 back-to-back transactions.
        do_reset();
        set_in(6'b111001, 32'h3000_0000, 32'h4000_0000);
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                got = grant;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL tie_wait: no grant within 10 cycles, expected transaction %0d", k);
            end else begin
                check($sformatf("tie%0d", k),
                      (RR && (k % 2 == 1)) ? 7'b1010000 : 7'b1110000,
                      (RR && (k % 2 == 1)) ? 32'h3000_0000 : 32'h4000_0000);
            end
            mem_valid = 1'b1;
            tick();
            mem_valid = 1'b0;
        end

        // Randomized traffic against the model.
        do_reset();
        mv_thr = 3;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) mv_thr = (n / 500) % 2 == 0 ? 0 : $urandom_range(1, 5);
            if (ifu_done || $urandom_range(0, 7) == 0) ifu_req = 1'b0;
            else if (!ifu_req && $urandom_range(0, 2) == 0) ifu_req = 1'b1;
            if (lsu_done || $urandom_range(0, 7) == 0) lsu_req = 1'b0;
            else if (!lsu_req && $urandom_range(0, 2) == 0) lsu_req = 1'b1;
            lsu_read  = $urandom_range(0, 1) == 1;
            lsu_write = $urandom_range(0, 1) == 1;
            mem_valid = $urandom_range(0, 9) < mv_thr;
            mem_idle  = $urandom_range(0, 1) == 1;
            ifu_addr  = $urandom;
            lsu_addr  = $urandom;
            model_step();
            tick();
            model_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
